// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, single-outstanding imem fetch,
// 2-deep instruction buffer and redirect/flush handling.
module fetch_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
  } ent_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            drop_q, drop_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      cnt_q, cnt_d;
  ent_t            e0_q, e0_d;
  ent_t            e1_q, e1_d;

  logic            ack;
  logic            accept;
  logic            pop;
  logic            misal;
  logic            issue;
  logic [1:0]      slot;
  ent_t            ent_new;

  always_comb begin
    ack     = req_q & imem_ack;
    accept  = ack & ~drop_q & ~redirect_valid;
    pop     = (cnt_q != 2'd0) & instr_ready & ~redirect_valid;
    misal   = redirect_target[1:0] != 2'b00;
    pc_en   = rst & (redirect_valid | accept);
    pc_next = redirect_valid ? redirect_target : pc + XLEN'(4);

    state_d = (state_q == IDLE) ? RUN : state_q;
    if (redirect_valid) begin
      state_d = misal ? FAULT : RUN;
    end
    fault_d = redirect_valid ? misal : fault_q;

    // a fetch in flight at redirect returns stale data
    drop_d = drop_q;
    if (redirect_valid & req_q & ~imem_ack) begin
      drop_d = 1'b1;
    end else if (ack) begin
      drop_d = 1'b0;
    end

    ent_new = '{ins: imem_rdata, pc: addr_q};
    e0_d    = e0_q;
    e1_d    = e1_q;
    slot    = cnt_q - {1'b0, pop};
    if (pop) begin
      e0_d = e1_q;
    end
    if (accept) begin
      if (slot == 2'd0) begin
        e0_d = ent_new;
      end else begin
        e1_d = ent_new;
      end
    end
    cnt_d = redirect_valid ? 2'd0
          : cnt_q + {1'b0, accept} - {1'b0, pop};

    // reserve a slot for the reply before issuing
    issue  = (state_d == RUN) & (~req_q | ack)
           & ~drop_d & (cnt_d < 2'd2);
    req_d  = issue | (req_q & ~ack);
    addr_d = issue ? (pc_en ? pc_next : pc) : addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = cnt_q != 2'd0;
  assign instr       = e0_q.ins;
  assign instr_pc    = e0_q.pc;
  assign fetch_fault = fault_q;

endmodule
